// File: rtl/weight_drm_reader.sv
// weight_drm_reader: streams a contiguous block of weight words out of the weight DRM array
// into a skid FIFO, optionally replaying the block per output tile (`define WEIGHT_RD_REPEAT_EN).
// Latency: start -> first weight_valid is RD_LATENCY+2 cycles; backpressure stalls issue via FIFO credits.

module weight_drm_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= nxt(wptr);
      if (pop)  rptr <= nxt(rptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is data-only; it needs no reset because count gates its visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_dat;
  end

  assign head_dat = mem[rptr];
endmodule

module weight_drm_reader #(
  parameter int DATA_WIDTH    = 1296,
  parameter int RD_ADDR_DEPTH = 8,
  parameter int RD_LATENCY    = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst,
  input  logic                     start,
  input  logic [RD_ADDR_DEPTH-1:0] base_addr,
  input  logic [RD_ADDR_DEPTH:0]   num_words,
  input  logic [7:0]               repeat_cnt,
  output logic                     busy,
  output logic                     done,
  output logic [RD_ADDR_DEPTH-1:0] WeightDRM_addr_rd,
  input  logic [DATA_WIDTH-1:0]    WeightDRM_data_rd,
  output logic [DATA_WIDTH-1:0]    weight_data,
  output logic                     weight_valid,
  input  logic                     weight_ready
);
  localparam int AW = RD_ADDR_DEPTH;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t          state;
  logic [AW-1:0]   base_q;
  logic [AW-1:0]   cur_addr;
  logic [AW:0]     nw_q;
  logic [AW:0]     words_left;
  logic [7:0]      passes_left;
  logic [RD_LATENCY:0] vpipe;
  logic [CW-1:0]   fifo_cnt;
  logic            push;
  logic            pop;
  logic [7:0]      rep_in;

`ifdef WEIGHT_RD_REPEAT_EN
  assign rep_in = repeat_cnt;
`else
  logic unused_repeat;
  assign rep_in        = '0;
  assign unused_repeat = ^repeat_cnt;
`endif

  logic          idle_go;
  logic [AW-1:0] iss_addr;
  logic [AW:0]   iss_left;
  logic [7:0]    iss_pass;
  logic [AW-1:0] reload_base;
  logic [AW:0]   reload_nw;
  logic          credit_ok;
  logic          do_issue;
  logic          final_pop;

  // The first read is issued on the start edge itself, so its operands come
  // straight from the command ports rather than from the captured registers.
  always_comb begin
    idle_go     = (state == IDLE) && start && (num_words != '0);
    iss_addr    = idle_go ? base_addr : cur_addr;
    iss_left    = idle_go ? num_words : words_left;
    iss_pass    = idle_go ? rep_in    : passes_left;
    reload_base = idle_go ? base_addr : base_q;
    reload_nw   = idle_go ? num_words : nw_q;
    // Counting this cycle's pop as a freed slot keeps the stream bubble-free.
    credit_ok   = ($countones(vpipe) + int'(fifo_cnt) - int'(pop)) < FIFO_DEPTH;
    do_issue    = idle_go || ((state == ISSUE) && credit_ok);
    final_pop   = (state == DRAIN) && pop && (fifo_cnt == CW'(1)) && (vpipe == '0);
  end

  assign push = vpipe[RD_LATENCY];
  assign pop  = weight_valid && weight_ready;
  assign weight_valid = (fifo_cnt != '0);

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state             <= IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      WeightDRM_addr_rd <= '0;
      vpipe             <= '0;
      base_q            <= '0;
      cur_addr          <= '0;
      nw_q              <= '0;
      words_left        <= '0;
      passes_left       <= '0;
    end else begin
      done  <= 1'b0;
      vpipe <= {vpipe[RD_LATENCY-1:0], do_issue};

      if ((state == IDLE) && start) begin
        base_q <= base_addr;
        nw_q   <= num_words;
        if (num_words == '0) done <= 1'b1;
        else                 busy <= 1'b1;
      end

      if (do_issue) begin
        WeightDRM_addr_rd <= iss_addr;
        if (iss_left == (AW+1)'(1)) begin
          if (iss_pass != '0) begin
            cur_addr    <= reload_base;
            words_left  <= reload_nw;
            passes_left <= iss_pass - 8'd1;
            state       <= ISSUE;
          end else begin
            state <= DRAIN;
          end
        end else begin
          cur_addr    <= iss_addr + 1'b1;
          words_left  <= iss_left - 1'b1;
          passes_left <= iss_pass;
          state       <= ISSUE;
        end
      end

      if (final_pop) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

  weight_drm_fifo #(
    .W     (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (rd_clk),
    .rst      (rd_rst),
    .push     (push),
    .push_dat (WeightDRM_data_rd),
    .pop      (pop),
    .head_dat (weight_data),
    .count    (fifo_cnt)
  );
endmodule

// File: tb/tb_weight_drm_reader.sv
// Self-checking bench for weight_drm_reader: table of commands replayed against a queue-based model
// of the expected word stream, with a latency-2 memory model and random downstream backpressure.
module tb_weight_drm_reader;
  localparam int DW = 1296;
  localparam int L  = 2;
`ifdef WEIGHT_RD_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic          rd_clk;
  logic          rd_rst;
  logic          start;
  logic [7:0]    base_addr;
  logic [8:0]    num_words;
  logic [7:0]    repeat_cnt;
  logic          busy;
  logic          done;
  logic [7:0]    WeightDRM_addr_rd;
  logic [DW-1:0] WeightDRM_data_rd;
  logic [DW-1:0] weight_data;
  logic          weight_valid;
  logic          weight_ready;

  int checks = 0;
  int errors = 0;

  weight_drm_reader #(
    .DATA_WIDTH(DW), .RD_ADDR_DEPTH(8), .RD_LATENCY(L), .FIFO_DEPTH(4)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .repeat_cnt(repeat_cnt), .busy(busy), .done(done),
    .WeightDRM_addr_rd(WeightDRM_addr_rd), .WeightDRM_data_rd(WeightDRM_data_rd),
    .weight_data(weight_data), .weight_valid(weight_valid), .weight_ready(weight_ready)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // Array model: data appears L cycles after the address is presented.
  logic [DW-1:0] mem [256];
  logic [7:0]    a_d [L];
  always @(posedge rd_clk) begin
    a_d[0] <= WeightDRM_addr_rd;
    for (int i = 1; i < L; i++) a_d[i] <= a_d[i-1];
  end
  assign WeightDRM_data_rd = mem[a_d[L-1]];

  typedef struct {
    logic [7:0] base;
    logic [8:0] nw;
    logic [7:0] rep;
    bit         rdy_rand;
    bit         poke;
    int         exp_words;
  } vec_t;

  vec_t tbl [9];

  task automatic tick;
    @(posedge rd_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual_lsw=%0h required_lsw=%0h", name, act[31:0], exp[31:0]);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    logic [7:0]    exp_addr [$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] prev_data;
    logic [7:0]    addr0;
    logic [7:0]    a;
    bit            prev_stall;
    bit            done_seen;
    int            passes, total, k, got, last_pop_k;

    passes = REP ? int'(v.rep) + 1 : 1;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < int'(v.nw); i++) begin
        a = 8'((int'(v.base) + i) % 256);
        exp_addr.push_back(a);
        exp_q.push_back(mem[a]);
      end
    total = exp_q.size();

    addr0        = WeightDRM_addr_rd;
    start        = 1'b1;
    base_addr    = v.base;
    num_words    = v.nw;
    repeat_cnt   = v.rep;
    weight_ready = 1'b1;
    tick;
    start      = 1'b0;
    k          = 1;
    got        = 0;
    last_pop_k = -100;
    done_seen  = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    while (!done_seen && k < 3000) begin
      weight_ready = v.rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v.nw != 0) begin
        if (k == 1) chk("busy_rise", busy, 1);
        if (k <= L + 1) chk("valid_early", weight_valid, 0);
        if (k == L + 2) chk("first_valid", weight_valid, 1);
        if (!v.rdy_rand && k <= total) chk("rd_addr", WeightDRM_addr_rd, exp_addr[k-1]);
      end else begin
        chk("zero_busy", busy, 0);
        chk("zero_addr_hold", WeightDRM_addr_rd, addr0);
      end
      if (prev_stall) begin
        chk("stall_valid", weight_valid, 1);
        chk_w("stall_data", weight_data, prev_data);
      end
      if (done) begin
        done_seen = 1'b1;
        chk("done_cycle", k, (v.nw == 0) ? 1 : last_pop_k + 1);
        chk("busy_at_done", busy, 0);
        chk("word_count", got, v.exp_words);
      end else if (weight_valid && weight_ready) begin
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk_w("word_data", weight_data, exp_q.pop_front());
        got++;
        last_pop_k = k;
      end
      prev_stall = weight_valid && !weight_ready;
      prev_data  = weight_data;
      if (v.poke && k == 3) begin
        start     = 1'b1;
        base_addr = 8'h80;
        num_words = 9'd9;
      end else begin
        start = 1'b0;
      end
      tick;
      k++;
    end
    chk("done_seen", done_seen, 1);
    chk("done_pulse", done, 0);
    chk("idle_valid", weight_valid, 0);
  endtask

  initial begin
    logic [1311:0] t;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 41; j++) t[j*32 +: 32] = $urandom;
      mem[i] = t[DW-1:0];
    end

    tbl[0] = '{8'h10, 9'd4,   8'd0, 1'b0, 1'b0, 4};
    tbl[1] = '{8'hFE, 9'd4,   8'd0, 1'b0, 1'b0, 4};
    tbl[2] = '{8'h30, 9'd20,  8'd0, 1'b1, 1'b0, 20};
    tbl[3] = '{8'h05, 9'd3,   8'd2, 1'b0, 1'b0, REP ? 9 : 3};
    tbl[4] = '{8'h60, 9'd0,   8'd0, 1'b0, 1'b0, 0};
    tbl[5] = '{8'h40, 9'd6,   8'd0, 1'b0, 1'b1, 6};
    tbl[6] = '{8'hA0, 9'd7,   8'd1, 1'b1, 1'b0, REP ? 14 : 7};
    tbl[7] = '{8'hC8, 9'd1,   8'd3, 1'b0, 1'b0, REP ? 4 : 1};
    tbl[8] = '{8'h00, 9'd256, 8'd0, 1'b1, 1'b0, 256};

    rd_rst       = 1'b1;
    start        = 1'b0;
    base_addr    = '0;
    num_words    = '0;
    repeat_cnt   = '0;
    weight_ready = 1'b1;
    repeat (3) tick;
    chk("rst_addr",  WeightDRM_addr_rd, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_valid", weight_valid, 0);
    rd_rst = 1'b0;
    tick;

    for (int n = 0; n < 9; n++) begin
      run_cmd(tbl[n]);
      repeat (2) tick;
    end

    // Abort after two issues: nothing may surface afterwards and done must stay low.
    start     = 1'b1;
    base_addr = 8'h20;
    num_words = 9'd8;
    tick;
    start = 1'b0;
    tick;
    chk("abort_second_addr", WeightDRM_addr_rd, 8'h21);
    rd_rst = 1'b1;
    tick;
    chk("abort_valid", weight_valid, 0);
    chk("abort_busy",  busy, 0);
    rd_rst = 1'b0;
    repeat (8) begin
      tick;
      chk("abort_no_done",  done, 0);
      chk("abort_no_valid", weight_valid, 0);
    end
    run_cmd(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/weight_drm_reader.md
# weight_drm_reader

Read-side sequencer for the weight DRM array. On a start command it walks a contiguous block of 144-bit-per-bank weight words, drives the array read address, and realigns the returned 1296-bit words to the array's fixed read latency. It delivers the words to the PE array through a valid/ready interface with a small skid FIFO, and can optionally replay the block several times, once per output tile. It sits between the weight DRM array read port and the convolution PE array, in the read clock domain.

## Interface
- DATA_WIDTH, 1296, width of one read word (9 banks x 144)
- RD_ADDR_DEPTH, 8, read address width
- RD_LATENCY, 1, cycles from address presented to data valid on WeightDRM_data_rd (1..3)
- FIFO_DEPTH, 4, output skid FIFO entries; must be at least RD_LATENCY+1
- rd_clk  in  1  clock
- rd_rst  in  1  synchronous active-high reset
- start  in  1  one-cycle command pulse
- base_addr  in  RD_ADDR_DEPTH  first word address, sampled on accepted start
- num_words  in  RD_ADDR_DEPTH+1  words per pass, sampled on accepted start
- repeat_cnt  in  8  passes minus one, sampled on accepted start
- busy  out  1  command in progress
- done  out  1  one-cycle pulse after the last word is accepted downstream
- WeightDRM_addr_rd  out  RD_ADDR_DEPTH  array read address
- WeightDRM_data_rd  in  DATA_WIDTH  array read data
- weight_data  out  DATA_WIDTH  FIFO head word
- weight_valid  out  1  FIFO non-empty
- weight_ready  in  1  downstream accepts the head word

## Operation
- States:
  - IDLE: start accepted only here; start while busy is ignored.
  - ISSUE: generates read addresses.
  - DRAIN: all reads issued; waits for the FIFO to empty.
  - IDLE: entered after DRAIN, with done pulsed.
- On accepted start with num_words==0: no reads; done pulses next cycle; busy stays 0.
- Issue condition in ISSUE: outstanding + fifo_count < FIFO_DEPTH, where outstanding counts issued reads not yet returned (at most RD_LATENCY).
- Each issue:
  - drive WeightDRM_addr_rd = cur_addr.
  - push a 1 into a RD_LATENCY-deep valid shift register.
  - cur_addr increments modulo 2^RD_ADDR_DEPTH, wrapping 255 -> 0 with no error.
- When the shift register's tail bit is 1, WeightDRM_data_rd is written into the FIFO. The credit rule guarantees the FIFO never overflows.
- When a pass's last word is issued:
  - with passes remaining, cur_addr reloads base_addr and the word counter reloads num_words.
  - otherwise the FSM moves to DRAIN.
- WeightDRM_addr_rd holds its last value when no read is issued.
- FIFO pop on weight_valid && weight_ready. A simultaneous push and pop leaves the count unchanged.
- done pulses the cycle after the final pop; busy falls in that same cycle.

## Timing
- Reset values:
  - WeightDRM_addr_rd = 0, busy = 0, done = 0, weight_valid = 0.
  - FIFO empty, valid shift register cleared, FSM in IDLE.
  - weight_data is don't-care while weight_valid is 0.
- start at cycle T:
  - busy = 1 at T+1.
  - first address presented at T+1.
  - first weight_valid at T+1+RD_LATENCY+1 (one FIFO write cycle).
- With weight_ready held at 1, one word is delivered per cycle after the first, with no bubbles, including across pass boundaries.
- Backpressure: weight_data and weight_valid hold stable while weight_valid && !weight_ready.
- rd_rst asserted mid-command aborts it:
  - in-flight returns are discarded and the FIFO is flushed.
  - done is not pulsed.
- Total words delivered = num_words x (repeat_cnt+1).

## Configuration
- WEIGHT_RD_REPEAT_EN
  - Defined: repeat_cnt is honored as described above.
  - Undefined: repeat_cnt is ignored and exactly one pass runs; the port remains present.

## Test plan
- Reset, then start with base_addr=0x10, num_words=4, repeat_cnt=0, weight_ready=1 -> addresses 0x10..0x13 on consecutive cycles; 4 words in order; done one cycle after the 4th pop.
- base_addr=0xFE, num_words=4 -> addresses 0xFE, 0xFF, 0x00, 0x01; data matches memory model contents.
- weight_ready toggled randomly, RD_LATENCY=2 -> no word lost or duplicated; FIFO count never exceeds 4; weight_data stable while stalled.
- With WEIGHT_RD_REPEAT_EN: num_words=3, repeat_cnt=2 -> 9 words, address sequence 5,6,7,5,6,7,5,6,7 for base 5. Without the macro: 3 words.
- num_words=0 -> done at T+1; busy never asserted; no address change. A start pulsed while busy is ignored.
- rd_rst asserted during ISSUE after 2 issues -> next cycle weight_valid=0 and busy=0; no done; a fresh start then behaves as in the first scenario.
